// File: rtl/mux_2to1_d.sv
// Parameterised 2-to-1 data multiplexer: zero-latency combinational result
// plus an enable-gated registered copy with a one-cycle valid strobe.
module mux_2to1_d #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             sel,
  input  logic             en,
  output logic [width-1:0] c,
  output logic [width-1:0] c_q,
  output logic             c_q_valid
);

  logic [width-1:0] c_q_reg;
  logic             c_q_valid_reg;

  // An if/else is used so a non-binary sel falls through to a instead of
  // merging the operands bit by bit.
  always_comb begin
    c = a;
    if (sel == 1'b1) begin
      c = b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q_reg       <= '0;
      c_q_valid_reg <= 1'b0;
    end else begin
      if (en) begin
        c_q_reg <= c;
      end
      c_q_valid_reg <= en;
    end
  end

  assign c_q       = c_q_reg;
  assign c_q_valid = c_q_valid_reg;

endmodule

// File: tb/tb_mux_2to1_d.sv
// Directed self-checking bench for mux_2to1_d: combinational sweeps, registered
// capture, reset priority, streaming, and width-1 / width-32 builds.
module tb_mux_2to1_d;

  logic       clk = 1'b0;
  logic       rst, sel, en;
  logic [7:0] a, b, c, c_q;
  logic       c_q_valid;

  logic        a1, b1, sel1, c1, c_q1, c_q_valid1;
  logic [31:0] a32, b32, c32, c_q32;
  logic        sel32, c_q_valid32;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mux_2to1_d #(.width(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .sel(sel), .en(en),
    .c(c), .c_q(c_q), .c_q_valid(c_q_valid)
  );

  mux_2to1_d #(.width(1)) dut_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .sel(sel1), .en(en),
    .c(c1), .c_q(c_q1), .c_q_valid(c_q_valid1)
  );

  mux_2to1_d #(.width(32)) dut_w32 (
    .clk(clk), .rst(rst), .a(a32), .b(b32), .sel(sel32), .en(en),
    .c(c32), .c_q(c_q32), .c_q_valid(c_q_valid32)
  );

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (c_q !== 8'h00 || c_q_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: c_q=%h c_q_valid=%b, want 00/0", c_q, c_q_valid);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sel_sweep(input logic s);
    logic [7:0] pa [5] = '{8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE0};
    logic [7:0] pb [5] = '{8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'hF0};
    logic [7:0] exp_c;
    sel = s; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = pa[i]; b = pb[i];
      exp_c = s ? pb[i] : pa[i];
      #30;
      vectors++;
      if (c !== exp_c || c_q !== 8'h00 || c_q_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL sweep sel=%b #%0d: c=%h c_q=%h v=%b, want %h/00/0",
                 s, i, c, c_q, c_q_valid, exp_c);
      end
    end
  endtask

  task automatic test_sel_flip();
    a = 8'hE0; b = 8'hF0; sel = 1'b0;
    #1;
    vectors++;
    if (c !== 8'hE0) begin
      miscompares++;
      $display("FAIL sel_flip before: c=%h, want e0", c);
    end
    sel = 1'b1;
    #1;
    vectors++;
    if (c !== 8'hF0) begin
      miscompares++;
      $display("FAIL sel_flip after: c=%h, want f0", c);
    end
  endtask

  task automatic test_capture();
    @(negedge clk);
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    rst = 1'b0; a = 8'h5A; b = 8'hC3; sel = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (c_q !== 8'hC3 || c_q_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL capture: c_q=%h v=%b, want c3/1", c_q, c_q_valid);
    end
    @(negedge clk);
    en = 1'b0; a = 8'h00; b = 8'h00;
    @(posedge clk); #1;
    vectors++;
    if (c_q !== 8'hC3 || c_q_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL capture_hold: c_q=%h v=%b, want c3/0", c_q, c_q_valid);
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; sel = 1'b0; a = 8'hFF; b = 8'h00;
    #1;
    vectors++;
    if (c !== 8'hFF) begin
      miscompares++;
      $display("FAIL rst_comb: c=%h, want ff", c);
    end
    @(posedge clk); #1;
    vectors++;
    if (c_q !== 8'h00 || c_q_valid !== 1'b0 || c !== 8'hFF) begin
      miscompares++;
      $display("FAIL rst_priority: c_q=%h v=%b c=%h, want 00/0/ff", c_q, c_q_valid, c);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (c_q !== 8'hFF || c_q_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL first_after_rst: c_q=%h v=%b, want ff/1", c_q, c_q_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [4] = '{8'h11, 8'h22, 8'h11, 8'h22};
    @(negedge clk);
    a = 8'h11; b = 8'h22; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = i[0];
      @(posedge clk); #1;
      vectors++;
      if (c_q !== exp_q[i] || c_q_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL stream #%0d: c_q=%h v=%b, want %h/1", i, c_q, c_q_valid, exp_q[i]);
      end
      @(negedge clk);
    end
    en = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (c_q !== 8'h22 || c_q_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_end: c_q=%h v=%b, want 22/0", c_q, c_q_valid);
    end
  endtask

  task automatic test_width_boundary();
    a1 = 1'b0; b1 = 1'b1; sel1 = 1'b1;
    a32 = 32'h0000_0000; b32 = 32'hFFFF_FFFF; sel32 = 1'b1;
    #1;
    vectors++;
    if (c1 !== 1'b1 || c32 !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL width_sel1: c1=%b c32=%h, want 1/ffffffff", c1, c32);
    end
    sel1 = 1'b0; sel32 = 1'b0;
    #1;
    vectors++;
    if (c1 !== 1'b0 || c32 !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL width_sel0: c1=%b c32=%h, want 0/00000000", c1, c32);
    end
    a32 = 32'hA5C3_0F96; b32 = 32'h5A3C_F069; sel32 = 1'b1;
    #1;
    vectors++;
    if (c32 !== 32'h5A3C_F069) begin
      miscompares++;
      $display("FAIL width32_pattern: c32=%h, want 5a3cf069", c32);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; sel = 1'b0; a = '0; b = '0;
    a1 = 1'b0; b1 = 1'b0; sel1 = 1'b0;
    a32 = '0; b32 = '0; sel32 = 1'b0;
    test_reset();
    test_sel_sweep(1'b0);
    test_sel_sweep(1'b1);
    test_sel_flip();
    test_capture();
    test_reset_priority();
    test_back_to_back();
    test_width_boundary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_2to1_d.md
Name: mux_2to1_d

Overview:
- Parameterised 2-to-1 data multiplexer, data-flow style.
- Selects between two WIDTH-bit operands with a single select bit.
- Provides a zero-latency combinational output plus an optional registered copy with a valid strobe.
- Used as a leaf routing primitive in datapaths: combinational output for in-cycle routing, registered output for timing-isolated consumers.

Parameters:
- width, 8, data width in bits of a, b, c and c_q. Legal range ≥1; default bench uses 8.

Ports:
- clk  input  1  system clock; all registered state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- a  input  width  data operand selected when sel=0.
- b  input  width  data operand selected when sel=1.
- sel  input  1  select: 0 → a, 1 → b.
- en  input  1  capture enable for the registered path.
- c  output  width  combinational mux result.
- c_q  output  width  registered mux result.
- c_q_valid  output  1  high for one cycle after each capture.

Behaviour:
- Combinational path:
  - c = (sel == 1'b1) ? b : a.
  - Pure continuous assignment, zero latency, independent of clk/rst.
  - Changes on a, b or sel propagate to c within the same delta/time step.
  - Non-binary sel (X/Z) drives c = a; c never holds a stale value.
  - Full-width bitwise selection: every bit of c comes from the same operand. No truncation, extension or arithmetic.
- Registered path, rising edge of clk:
  - rst=1: c_q ← 0, c_q_valid ← 0. rst has priority over en.
  - rst=0, en=1: c_q ← c (value of sel/a/b sampled at that edge), c_q_valid ← 1.
  - rst=0, en=0: c_q holds, c_q_valid ← 0.
- Latency:
  - c is 0 cycles.
  - c_q / c_q_valid is 1 cycle after the enabling edge.
- Back-to-back en=1 captures every cycle; c_q_valid stays high continuously.
- Reset asserted mid-stream clears c_q on that edge, regardless of en. First capture is possible on the first edge after rst deasserts.
- Reset values: c_q=0, c_q_valid=0. c has no reset value; it always tracks its inputs, including during reset.
- No internal state other than c_q and c_q_valid. No FSM.

Decomposition:
- No shared package required. width is a module parameter only; no typedefs or constants are shared.
- No sub-module. A single flat module: one continuous assignment plus one always block for the register.

Test Plan:
- sel=0 sweep, rst=0, en=0, width=8. Drive (a,b) = (A0,B0), (B0,C0), (C0,D0), (D0,E0), (E0,F0), 30 time units each → c = A0, B0, C0, D0, E0 respectively. c_q is unchanged and c_q_valid=0.
- sel=1 sweep, same five (a,b) pairs → c = B0, C0, D0, E0, F0. The sel 0→1 transition alone with a=E0, b=F0 flips c from E0 to F0 with no clock edge.
- Registered capture: rst pulsed 1 cycle, then a=8'h5A, b=8'hC3, sel=1, en=1 for one edge → next cycle c_q=C3, c_q_valid=1. Following edge with en=0 → c_q=C3, c_q_valid=0.
- Reset priority: c_q=C3, then rst=1 and en=1 at the same edge with sel=0, a=8'hFF → c_q=00, c_q_valid=0. During reset, c still shows FF.
- Streaming: en=1 for 4 consecutive edges with sel alternating 0,1,0,1, a=8'h11, b=8'h22 → c_q sequence 11, 22, 11, 22 on successive cycles; c_q_valid held high for 4 cycles.
- Width boundary: width=1 and width=32 builds. With sel=1, a=0, b=all-ones → c=all-ones. With sel=0 → c=0, bit-exact across all positions.
